// File: rtl/vend_pkg.sv
// Shared types for the parametrised vending controller: coin codes, FSM state
// encoding (also exported on the state port) and coin face values in nickels.
package vend_pkg;

    typedef enum logic [1:0] {
        NICKEL  = 2'b00,
        DIME    = 2'b01,
        QUARTER = 2'b10,
        SLUG    = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        COLLECT  = 2'b01,
        DISPENSE = 2'b10,
        CHANGE   = 2'b11
    } state_t;

    function automatic logic [2:0] coin_value(coin_t c);
        case (c)
            NICKEL:  return 3'd1;
            DIME:    return 3'd2;
            QUARTER: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_ctr.sv
// Loadable down-counter holding the nickels still owed; pulses once per decrement.
// Loaded by both the post-vend remainder path and the refund path.
module vend_change_ctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         pulse_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o   = cnt_q;
    assign last_o  = (cnt_q == W'(1));
    assign pulse_o = en_i && (cnt_q != '0);

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending controller: collects nickel/dime/quarter credit against PRICE, vends one
// item, returns excess as nickel pulses. Define VEND_TIMEOUT_EN for idle auto-refund.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int  PRICE    = 4,
    parameter int  TIMEOUT  = 255,
    localparam int CREDIT_W = $clog2(PRICE + 5) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic                coin_ready,
    output logic                coin_reject,
    output logic                dispense,
    output logic                change_nickel,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state
);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                rej_q, rej_d;

    logic                accept, refund, timeout_hit;
    logic [CREDIT_W-1:0] sum, rem;
    logic                ld, ctr_last, ctr_pulse;
    logic [CREDIT_W-1:0] ld_val, ctr_cnt;
    coin_t               coin;

    assign coin       = coin_t'(coin_type);
    assign coin_ready = (state_q == IDLE) || (state_q == COLLECT);
    assign accept     = coin_valid && coin_ready && (coin != SLUG);
    assign sum        = credit_q + (accept ? CREDIT_W'(coin_value(coin)) : '0);
    assign rem        = credit_q - CREDIT_W'(PRICE);
    assign refund     = (state_q == COLLECT) && (cancel || timeout_hit);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        ld       = 1'b0;
        ld_val   = '0;
        rej_d    = coin_valid && ((coin == SLUG) || !coin_ready);
        case (state_q)
            IDLE, COLLECT: begin
                // A vend takes priority over a simultaneous cancel.
                if (sum >= CREDIT_W'(PRICE)) begin
                    state_d  = DISPENSE;
                    credit_d = sum;
                end else if (refund) begin
                    state_d  = CHANGE;
                    ld       = 1'b1;
                    ld_val   = sum;
                    credit_d = '0;
                end else if (accept) begin
                    state_d  = COLLECT;
                    credit_d = sum;
                end
            end
            DISPENSE: begin
                credit_d = '0;
                if (rem != '0) begin
                    state_d = CHANGE;
                    ld      = 1'b1;
                    ld_val  = rem;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                if (ctr_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            rej_q    <= rej_d;
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int IDLE_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Counts coin-free COLLECT cycles; the TIMEOUT-th one acts as cancel.
    assign timeout_hit = (state_q == COLLECT) && !accept && (idle_q == IDLE_W'(TIMEOUT - 1));
    assign idle_d      = (state_d == COLLECT && !accept) ? idle_q + IDLE_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) idle_q <= '0;
        else      idle_q <= idle_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    vend_change_ctr #(.W(CREDIT_W)) u_change (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ld),
        .load_val_i(ld_val),
        .en_i      (state_q == CHANGE),
        .cnt_o     (ctr_cnt),
        .last_o    (ctr_last),
        .pulse_o   (ctr_pulse)
    );

    assign credit        = (state_q == CHANGE) ? ctr_cnt : credit_q;
    assign state         = state_q;
    assign dispense      = (state_q == DISPENSE);
    assign change_nickel = ctr_pulse;
    assign coin_reject   = rej_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (credit <= CREDIT_W'(PRICE + 4));
            assert (PRICE >= 1 && PRICE <= 60 && TIMEOUT >= 1);
        end
    end

endmodule
